sort64_ctrl: RTL and testbench
==============================

Name: sort64_ctrl

Overview:
- Streaming sequencer wrapped around the 64-element combinational bitonic sort datapath.
- Collects up to 64 elements one per cycle over a valid/ready input stream and pads short frames.
- Presents the frame to the sort core, holds it for a fixed number of settle cycles, captures the result, then streams the sorted elements out over a valid/ready output.
- Makes the single combinational core usable from a registered, clocked subsystem.

Parameters:
- WIDTH, 32, element width in bits; must match the core's WIDTH.
- CORE_LAT, 2, settle cycles allowed between core input stable and result capture (≥1; multicycle-path budget).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_direction  in  1  0=ascending, 1=descending; sampled on the first accepted element of a frame
- s_valid  in  1  input element valid
- s_ready  out  1  controller can accept an element
- s_data  in  WIDTH  input element
- s_last  in  1  final element of frame
- m_valid  out  1  output element valid
- m_ready  in  1  downstream accepts
- m_data  out  WIDTH  sorted element
- m_last  out  1  final output element of frame
- core_direction  out  1  to core direction
- core_in_bus  out  64*WIDTH  to core in_bus; element i at bits [i*WIDTH +: WIDTH]
- core_out_bus  in  64*WIDTH  from core out_bus
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, core_direction=0, buffer=0, counters=0, state=IDLE.
  - Reset mid-frame aborts the frame; no partial output.
  - s_ready rises on the first cycle after rst deasserts.
- State IDLE:
  - s_ready=1.
  - On a handshake (s_valid&&s_ready): store element 0, latch cfg_direction into dir_q, set cnt=1, go to LOAD.
  - If that same beat has s_last, go to SETTLE directly.
- State LOAD:
  - s_ready=1.
  - Each handshake writes buf[cnt] and increments cnt.
  - Leave to SETTLE when the handshake carries s_last, or when cnt reaches 64 (element 63 accepted); the 64th element is treated as last even without s_last.
  - n_q (frame length, 7 bits, range 1..64) = cnt after the final write.
- Padding (on entry to SETTLE):
  - Slots n_q..63 are filled with the pad value: all-ones if dir_q=0, all-zeros if dir_q=1.
  - Pads therefore sort to the tail and are never emitted.
  - Keys are unsigned.
- State SETTLE:
  - s_ready=0.
  - core_in_bus=buf and core_direction=dir_q, held stable throughout.
  - A wait counter runs CORE_LAT cycles.
  - On the final cycle, capture core_out_bus into res_q, set ocnt=0, go to DRAIN.
- State DRAIN:
  - s_ready=0; m_valid=1; m_data=res_q[ocnt]; m_last=(ocnt==n_q-1).
  - Each handshake (m_valid&&m_ready) increments ocnt.
  - The handshake with m_last=1 returns to IDLE, with m_valid low the next cycle.
  - m_data/m_last are stable while m_valid && !m_ready.
- Outputs are registered or decoded only from registered state; no combinational path from s_valid or m_ready to any output.
- Throughput:
  - 1 element/cycle in and out.
  - Frame latency from the last input handshake to the first m_valid = CORE_LAT+1 cycles.
  - No overlap between frames: single buffer, s_ready=0 from SETTLE until DRAIN completes.
- s_valid while s_ready=0 is ignored, with no side effects.
- cfg_direction changes mid-frame have no effect.

Decomposition:
- Shared package sort_pkg:
  - N_ELEM=64, CNT_W=7
  - state enum ctrl_state_t {IDLE, LOAD, SETTLE, DRAIN}
  - function pad_val(dir)
- Sub-module: sort64_frame_buf (64×WIDTH register array; indexed write, pad fill, flat bus read), instantiated twice (load buffer, result buffer).
- The sort core itself is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Full ascending frame: inputs 63,62,…,0 with s_last on the 64th, dir=0, m_ready=1 → m_data 0..63 on consecutive cycles, m_last on value 63, first m_valid CORE_LAT+1 cycles after last input.
- Short descending frame: 5 elements {7,3,9,1,5} with s_last, dir=1 → outputs 9,7,5,3,1 and m_last on 1; no pad (0) emitted; busy returns to 0.
- Single element: s_data=0xDEADBEEF with s_last in IDLE → one output 0xDEADBEEF, m_valid and m_last high together.
- Backpressure: full frame with m_ready toggling 1,0,0,1 → m_data held during stalls, all 64 delivered in order, none duplicated.
- No s_last: 64 elements without s_last, then 3 more offered → s_ready=0 after the 64th; extras not accepted until DRAIN ends; m_last on output 64.
- Reset mid-LOAD after 10 elements → next cycle s_ready=1, m_valid=0; a new 3-element frame sorts correctly with no stale data.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the 64-element sort sequencer.
//   N_ELEM       : elements per frame
//   CNT_W        : width of a frame length (1..64)
//   IDX_W        : width of an element index (0..63)
//   ctrl_state_t : sequencer states
//   pad_val()    : pad bit for unused slots, chosen so pads sort to the tail
package sort_pkg;

    localparam int unsigned N_ELEM = 64;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        DRAIN
    } ctrl_state_t;

    // Ascending (dir=0) pads with all-ones, descending (dir=1) with all-zeros.
    function automatic logic pad_val(input logic dir);
        return ~dir;
    endfunction

endpackage

// File: rtl/sort64_frame_buf.sv
// 64 x WIDTH register array holding one frame.
//   clk, rst            : clock, synchronous active-high reset (clears array)
//   i_wr_en/idx/data    : single indexed element write
//   i_pad_en/from/val   : fill slots i_pad_from..63 with i_pad_val
//   i_cap_en/i_cap_bus  : capture a whole flat bus (highest priority)
//   o_bus               : flat read, element i at [i*WIDTH +: WIDTH]
module sort64_frame_buf
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [IDX_W-1:0]        i_wr_idx,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_pad_en,
    input  logic [CNT_W-1:0]        i_pad_from,
    input  logic [WIDTH-1:0]        i_pad_val,
    input  logic                    i_cap_en,
    input  logic [N_ELEM*WIDTH-1:0] i_cap_bus,
    output logic [N_ELEM*WIDTH-1:0] o_bus
);

    logic [N_ELEM-1:0][WIDTH-1:0] r_mem;

    // Per-slot update: capture beats indexed write beats pad fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (i_cap_en) begin
                    r_mem[i] <= i_cap_bus[i*WIDTH +: WIDTH];
                end else if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_mem[i] <= i_wr_data;
                end else if (i_pad_en && (CNT_W'(i) >= i_pad_from)) begin
                    r_mem[i] <= i_pad_val;
                end
            end
        end
    end

    assign o_bus = r_mem;

endmodule

// File: rtl/sort64_ctrl.sv
// Streaming sequencer around the external 64-element combinational sort core.
// Loads a frame over s_*, pads it, holds it on core_in_bus for CORE_LAT
// cycles, captures core_out_bus, then drains the sorted frame over m_*.
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_direction            : 0 ascending / 1 descending, taken on first beat
//   s_valid/s_ready/s_data/s_last : input stream
//   m_valid/m_ready/m_data/m_last : output stream
//   core_direction, core_in_bus   : drive the sort core
//   core_out_bus             : sort core result
//   busy                     : high whenever not IDLE
module sort64_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CORE_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_direction,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic                    core_direction,
    output logic [N_ELEM*WIDTH-1:0] core_in_bus,
    input  logic [N_ELEM*WIDTH-1:0] core_out_bus,
    output logic                    busy
);

    localparam int unsigned WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam int unsigned BUS_W  = N_ELEM * WIDTH;

    ctrl_state_t        r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ocnt;
    logic [CNT_W-1:0]   r_n;
    logic [WAIT_W-1:0]  r_wait;

    logic               w_hs_in;
    logic               w_in_final;
    logic               w_dir;
    logic               w_cap_en;
    logic [CNT_W-1:0]   w_pad_from;
    logic [IDX_W-1:0]   w_next_ocnt;
    logic [WIDTH-1:0]   w_pad_word;
    logic [WIDTH-1:0]   w_next_data;
    logic [BUS_W-1:0]   w_res_bus;

    assign w_hs_in     = s_valid && s_ready;
    // r_cnt is 0 in IDLE, so the 64-element cap only triggers in LOAD.
    assign w_in_final  = w_hs_in && (s_last || (r_cnt == IDX_W'(N_ELEM - 1)));
    // The first beat's direction is not yet in core_direction.
    assign w_dir       = (r_state == IDLE) ? cfg_direction : core_direction;
    assign w_pad_word  = {WIDTH{pad_val(w_dir)}};
    assign w_pad_from  = CNT_W'(r_cnt) + CNT_W'(1);
    assign w_cap_en    = (r_state == SETTLE) && (r_wait == WAIT_W'(CORE_LAT - 1));
    assign w_next_ocnt = r_ocnt + IDX_W'(1);
    assign w_next_data = w_res_bus[32'(w_next_ocnt) * WIDTH +: WIDTH];

    // Load buffer: its registered contents drive the core directly.
    sort64_frame_buf #(.WIDTH(WIDTH)) u_load_buf (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_hs_in),
        .i_wr_idx   (r_cnt),
        .i_wr_data  (s_data),
        .i_pad_en   (w_in_final),
        .i_pad_from (w_pad_from),
        .i_pad_val  (w_pad_word),
        .i_cap_en   (1'b0),
        .i_cap_bus  ('0),
        .o_bus      (core_in_bus)
    );

    // Result buffer: captures the core output at the end of SETTLE.
    sort64_frame_buf #(.WIDTH(WIDTH)) u_res_buf (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (1'b0),
        .i_wr_idx   ('0),
        .i_wr_data  ('0),
        .i_pad_en   (1'b0),
        .i_pad_from ('0),
        .i_pad_val  ('0),
        .i_cap_en   (w_cap_en),
        .i_cap_bus  (core_out_bus),
        .o_bus      (w_res_bus)
    );

    // Sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_ocnt         <= '0;
            r_n            <= '0;
            r_wait         <= '0;
            s_ready        <= 1'b0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_data         <= '0;
            busy           <= 1'b0;
            core_direction <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (w_hs_in) begin
                        core_direction <= cfg_direction;
                        busy           <= 1'b1;
                        if (s_last) begin
                            r_state <= SETTLE;
                            s_ready <= 1'b0;
                            r_n     <= CNT_W'(1);
                            r_wait  <= '0;
                        end else begin
                            r_state <= LOAD;
                            r_cnt   <= IDX_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (w_hs_in) begin
                        if (w_in_final) begin
                            r_state <= SETTLE;
                            s_ready <= 1'b0;
                            r_n     <= w_pad_from;
                            r_cnt   <= '0;
                            r_wait  <= '0;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end
                end
                SETTLE: begin
                    if (w_cap_en) begin
                        r_state <= DRAIN;
                        r_ocnt  <= '0;
                        m_valid <= 1'b1;
                        // Result buffer is loaded on this same edge.
                        m_data  <= core_out_bus[WIDTH-1:0];
                        m_last  <= (r_n == CNT_W'(1));
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            r_state <= IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            r_ocnt <= w_next_ocnt;
                            m_data <= w_next_data;
                            m_last <= (CNT_W'(w_next_ocnt) == (r_n - CNT_W'(1)));
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort64_ctrl.sv
// Directed bench for sort64_ctrl with a behavioural sort core attached.
module tb_sort64_ctrl;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CORE_LAT = 2;
    localparam int unsigned BUS_W    = 64 * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_direction;
    logic              s_valid;
    logic              s_ready;
    logic [WIDTH-1:0]  s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_data;
    logic              m_last;
    logic              core_direction;
    logic [BUS_W-1:0]  core_in_bus;
    logic [BUS_W-1:0]  core_out_bus;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cyc = 0;
    logic [WIDTH-1:0] exp_q[$];

    sort64_ctrl #(.WIDTH(WIDTH), .CORE_LAT(CORE_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_direction  (cfg_direction),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .core_direction (core_direction),
        .core_in_bus    (core_in_bus),
        .core_out_bus   (core_out_bus),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the combinational bitonic core.
    function automatic logic [BUS_W-1:0] sort_bus(input logic [BUS_W-1:0] b,
                                                  input logic dir);
        logic [WIDTH-1:0] a [64];
        logic [WIDTH-1:0] t;
        logic [BUS_W-1:0] r;
        for (int i = 0; i < 64; i++) a[i] = b[i*WIDTH +: WIDTH];
        for (int i = 0; i < 63; i++)
            for (int j = 0; j < 63 - i; j++)
                if (dir ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 64; i++) r[i*WIDTH +: WIDTH] = a[i];
        return r;
    endfunction

    assign core_out_bus = sort_bus(core_in_bus, core_direction);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer one element from a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 64'(s_ready), 64'(1));
        hs_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Drain exp_q.size() elements; mode 1 drives m_ready as 1,0,0,1 repeating.
    task automatic recv(input int mode, input string tag);
        int got = 0;
        int waitc = 0;
        int ph = 0;
        int first_cyc = -1;
        int n;
        logic stalled = 1'b0;
        logic [WIDTH-1:0] held = '0;
        n = exp_q.size();
        while (got < n && waitc < 2000) begin
            m_ready = (mode == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
            ph++;
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled) chk({tag, "_hold"}, 64'(m_data), 64'(held));
                if (m_ready) begin
                    chk({tag, "_data"}, 64'(m_data), 64'(exp_q[got]));
                    chk({tag, "_last"}, 64'(m_last), 64'(got == n - 1));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = m_data;
                end
            end
            waitc++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
        chk({tag, "_lat"}, 64'(first_cyc - hs_cyc), 64'(CORE_LAT + 1));
        chk({tag, "_mvalid_off"}, 64'(m_valid), 64'(0));
        chk({tag, "_busy_off"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        cfg_direction = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_last",  64'(m_last), 64'(0));
        chk("rst_m_data",  64'(m_data), 64'(0));
        chk("rst_busy",    64'(busy), 64'(0));
        chk("rst_core_dir", 64'(core_direction), 64'(0));
        chk("rst_core_in", 64'(core_in_bus[63:0]), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));

        // Full ascending frame 63..0.
        cfg_direction = 1'b0;
        for (int i = 0; i < 64; i++) send(WIDTH'(63 - i), i == 63);
        chk("full_s_ready_low", 64'(s_ready), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(WIDTH'(i));
        recv(0, "full");

        // Short descending frame; direction flips after the first beat.
        cfg_direction = 1'b1;
        send(32'd7, 1'b0);
        cfg_direction = 1'b0;
        send(32'd3, 1'b0);
        send(32'd9, 1'b0);
        send(32'd1, 1'b0);
        send(32'd5, 1'b1);
        chk("short_core_dir", 64'(core_direction), 64'(1));
        exp_q = '{32'd9, 32'd7, 32'd5, 32'd3, 32'd1};
        recv(0, "short");

        // Single element frame.
        cfg_direction = 1'b0;
        send(32'hDEADBEEF, 1'b1);
        exp_q = '{32'hDEADBEEF};
        recv(0, "single");

        // Backpressure on a permuted full frame.
        for (int i = 0; i < 64; i++) send(WIDTH'(((i * 37) % 64) * 1000), i == 63);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(WIDTH'(i * 1000));
        recv(1, "bp");

        // 64 elements without s_last, then extras held on the input.
        for (int i = 0; i < 64; i++) send(WIDTH'(200 + i), 1'b0);
        s_valid = 1'b1;
        s_data  = 32'd100;
        chk("nolast_s_ready_low", 64'(s_ready), 64'(0));
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(WIDTH'(200 + i));
        recv(0, "nolast");
        send(32'd100, 1'b0);
        send(32'd50, 1'b0);
        send(32'd75, 1'b1);
        exp_q = '{32'd50, 32'd75, 32'd100};
        recv(0, "extras");

        // Reset in the middle of LOAD.
        for (int i = 0; i < 10; i++) send(WIDTH'(i + 1), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", 64'(s_ready), 64'(1));
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        send(32'd30, 1'b0);
        send(32'd10, 1'b0);
        send(32'd20, 1'b1);
        exp_q = '{32'd10, 32'd20, 32'd30};
        recv(0, "midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
